// File: rtl/slave_rx_port.sv
// Serial-to-parallel bus slave receive port: collects address, burst count and
// write data bit-serially, issues local memory writes or a read request.
module slave_rx_port #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 select,
  input  logic                 master_valid,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 rx_address,
  input  logic                 rx_burst,
  input  logic                 rx_data,
  input  logic                 rd_done,
  output logic                 slave_ready,
  output logic                 mem_we,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 rd_start,
  output logic [ADDR_LEN-1:0]  rd_addr,
  output logic [BURST_LEN-1:0] rd_len,
  output logic                 rx_done
);

  localparam int MAX_AB  = (ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN;
  localparam int MAX_LEN = (MAX_AB > DATA_LEN) ? MAX_AB : DATA_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, BURST, WDATA, WSTORE, RREQ, RWAIT, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_LEN-1:0]  addr_sr_q, addr_sr_d;
  logic [BURST_LEN-1:0] burst_sr_q, burst_sr_d;
  logic [BURST_LEN-1:0] burst_q, burst_d;
  logic [BURST_LEN-1:0] idx_q, idx_d;
  logic [DATA_LEN-1:0]  data_sr_q, data_sr_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_LEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic                 rd_start_q, rd_start_d;
  logic [ADDR_LEN-1:0]  rd_addr_q, rd_addr_d;
  logic [BURST_LEN-1:0] rd_len_q, rd_len_d;
  logic                 rx_done_q, rx_done_d;

  logic [BURST_LEN-1:0] burst_full;
  logic [BURST_LEN-1:0] burst_eff;
  logic [DATA_LEN-1:0]  word_full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_sr_d   = addr_sr_q;
    burst_sr_d  = burst_sr_q;
    burst_d     = burst_q;
    idx_d       = idx_q;
    data_sr_d   = data_sr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_start_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    rx_done_d   = 1'b0;
    burst_full  = {rx_burst, burst_sr_q[BURST_LEN-1:1]};
    burst_eff   = (burst_full == '0) ? BURST_LEN'(1) : burst_full;
    word_full   = {rx_data, data_sr_q[DATA_LEN-1:1]};

    // Outputs are registered: strobes and their payload load on the edge
    // that enters WSTORE / RREQ / DONE, so they line up with that state.
    case (state_q)
      IDLE: begin
        if (select && master_valid) begin
          addr_sr_d = {rx_address, addr_sr_q[ADDR_LEN-1:1]};
          cnt_d     = CNT_W'(1);
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (!select) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (master_valid) begin
          addr_sr_d = {rx_address, addr_sr_q[ADDR_LEN-1:1]};
          if (cnt_q == CNT_W'(ADDR_LEN - 1)) begin
            cnt_d   = '0;
            state_d = BURST;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      BURST: begin
        if (!select) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (master_valid) begin
          burst_sr_d = burst_full;
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            cnt_d   = '0;
            burst_d = burst_eff;
            idx_d   = '0;
            if (write_en) begin
              state_d = WDATA;
            end else if (read_en) begin
              rd_start_d = 1'b1;
              rd_addr_d  = addr_sr_q;
              rd_len_d   = burst_eff;
              state_d    = RREQ;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WDATA: begin
        if (!select) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (master_valid) begin
          data_sr_d = word_full;
          if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
            cnt_d       = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_sr_q + ADDR_LEN'(idx_q);
            mem_wdata_d = word_full;
            state_d     = WSTORE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WSTORE: begin
        if ((idx_q + BURST_LEN'(1)) < burst_q) begin
          idx_d   = idx_q + BURST_LEN'(1);
          state_d = WDATA;
        end else begin
          rx_done_d = 1'b1;
          state_d   = DONE;
        end
      end
      RREQ: state_d = RWAIT;
      RWAIT: begin
        if (rd_done) begin
          rx_done_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_sr_q   <= '0;
      burst_sr_q  <= '0;
      burst_q     <= '0;
      idx_q       <= '0;
      data_sr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_start_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      rx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_sr_q   <= addr_sr_d;
      burst_sr_q  <= burst_sr_d;
      burst_q     <= burst_d;
      idx_q       <= idx_d;
      data_sr_q   <= data_sr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_start_q  <= rd_start_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      rx_done_q   <= rx_done_d;
    end
  end

  assign slave_ready = (state_q == IDLE) || (state_q == ADDR) ||
                       (state_q == BURST) || (state_q == WDATA);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_start  = rd_start_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign rx_done   = rx_done_q;

endmodule

// File: doc/slave_rx_port.md
SLAVE_RX_PORT -- requirements
Module: slave_rx_port

Interface
REQ-001 Parameters SHALL be: ADDR_LEN, 12, local address width; DATA_LEN, 8, data word width; BURST_LEN, 13, burst count width.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- select  in  1  this slave is addressed by the bus
- master_valid  in  1  serial bits on rx_* lines are valid this cycle
- write_en  in  1  transaction is a write
- read_en  in  1  transaction is a read
- rx_address  in  1  serial address, LSB first
- rx_burst  in  1  serial burst count, LSB first
- rx_data  in  1  serial write data, LSB first
- rd_done  in  1  local read engine finished
- slave_ready  out  1  block can accept serial bits
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_LEN  write address
- mem_wdata  out  DATA_LEN  write data
- rd_start  out  1  one-cycle read request strobe
- rd_addr  out  ADDR_LEN  read base address
- rd_len  out  BURST_LEN  read word count
- rx_done  out  1  one-cycle transaction-complete pulse

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, BURST, WDATA, WSTORE, RREQ, RWAIT, DONE.
REQ-004 A bit SHALL be accepted only on a cycle with select=1, master_valid=1 and slave_ready=1; on other cycles in ADDR/BURST/WDATA, shift registers and counters SHALL hold.
REQ-005 IDLE -> ADDR when select=1 and master_valid=1; that cycle's rx_address bit SHALL be captured as address bit 0.
REQ-006 ADDR SHALL capture ADDR_LEN bits total, then go to BURST; BURST SHALL capture BURST_LEN bits from rx_burst.
REQ-007 A captured burst count of 0 SHALL be treated as 1.
REQ-008 On the last burst bit: write_en=1 -> WDATA; else read_en=1 -> RREQ; else -> IDLE with no rx_done. write_en has priority when both are high.
REQ-009 WDATA SHALL capture DATA_LEN bits from rx_data, then go to WSTORE.
REQ-010 WSTORE SHALL last exactly one cycle with mem_we=1, mem_wdata = word just captured, mem_addr = (base + word_index) mod 2^ADDR_LEN.
REQ-011 After WSTORE: if word_index+1 < burst, increment word_index and go to WDATA; else go to DONE.
REQ-012 RREQ SHALL last one cycle with rd_start=1, rd_addr = base and rd_len = effective burst, then go to RWAIT.
REQ-013 RWAIT SHALL stay until rd_done=1, then go to DONE.
REQ-014 DONE SHALL last one cycle with rx_done=1, then return to IDLE.
REQ-015 slave_ready SHALL be 1 in IDLE, ADDR, BURST and WDATA, and 0 in WSTORE, RREQ, RWAIT and DONE.
REQ-016 Deassertion of select in ADDR, BURST or WDATA SHALL abort to IDLE on the next edge: partial word discarded, no mem_we, no rx_done.
REQ-017 Deassertion of select in WSTORE, RREQ, RWAIT or DONE SHALL NOT abort the transaction.
REQ-018 Latency: last data bit accepted at edge n -> mem_we high in cycle n+1; after the final word, rx_done high in cycle n+2.
REQ-019 mem_addr/mem_wdata SHALL hold their last value outside WSTORE; rd_addr/rd_len SHALL hold their last value outside RREQ.

Reset
REQ-020 reset=1 at a clock edge SHALL force IDLE in any state, including mid-transfer.
REQ-021 reset=1 SHALL clear all shift registers and counters.
REQ-022 Output reset values SHALL be: slave_ready=1; mem_we, rd_start, rx_done=0; mem_addr, mem_wdata, rd_addr, rd_len=0.

Verification
REQ-023 Single write: addr 0x0A5, burst 1, data 0x3C, master_valid held high -> exactly one mem_we, addr 0x0A5, data 0x3C; rx_done 1 cycle later.
REQ-024 Burst write with wrap: addr 0xFFE, burst 3, data 0x11,0x22,0x33 -> mem_we at 0xFFE, 0xFFF, 0x000 with those data; exactly one rx_done.
REQ-025 Read: addr 0x100, burst 5, read_en=1 -> one rd_start with rd_addr=0x100 and rd_len=5; rd_done after 7 cycles -> rx_done on the next cycle.
REQ-026 Stalls and burst 0: master_valid low for 3 cycles mid-address and mid-data, burst 0, data 0x81 -> same result as unstalled: one write of 0x81.
REQ-027 Abort: select dropped after 4 data bits -> no mem_we, no rx_done, IDLE with slave_ready=1; next transaction completes normally.
REQ-028 Reset mid-burst after the 2nd mem_we of 4 -> all outputs at reset values; no further mem_we.
